timer_sched: RTL

//  Bus-mapped scheduler that time-shares one 16-bit decrementer among 4 software-visible timer channels.
//  A prescaler generates ticks; on each tick an FSM sweeps channels 0..3, one per clock, decrementing,

---
 rtl/timer_sched_if.sv | 12 +
 rtl/timer_sched.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/timer_sched_if.sv
// CPU peripheral bus seen by timer_sched: address, write data and strobes in; read data and interrupt out.
interface timer_sched_if;
  logic [3:0] AD;
  logic [7:0] DI;
  logic [7:0] DO;
  logic       rw;
  logic       cs;
  logic       intr;

  modport master (output AD, DI, rw, cs, input DO, intr);
  modport slave  (input AD, DI, rw, cs, output DO, intr);
endinterface

// File: rtl/timer_sched.sv
// Prescaled tick scheduler sweeping one shared 16-bit decrementer across NCH timer channels,
// with masked pending flags priority-encoded into a registered interrupt and a read-only vector.
module timer_sched #(
  parameter int          NCH       = 4,
  parameter logic [15:0] PRESC_RST = 16'd999
) (
  input logic          clk,
  input logic          rst,
  timer_sched_if.slave bus
);
  localparam logic [3:0] CH_MASK  = 4'((1 << NCH) - 1);
  localparam logic [1:0] LAST_IDX = 2'(NCH - 1);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_idx, w_idx_nxt;
  logic        r_tick_pend, w_tick_pend_nxt, w_ovr_set;
  logic [15:0] r_presc, r_pc;
  logic [7:0]  r_ctrl, r_hold;
  logic [3:0]  r_pend, r_mask;
  logic        r_ovr, r_intr;
  logic [15:0] r_rld [4];
  logic [15:0] r_cnt [4];

  logic        w_wr, w_tick, w_wr_ctrl, w_wr_hold;
  logic [3:0]  w_wr_cnt, w_pend_set, w_pend_clr, w_act;
  logic        w_en_cur, w_per_cur, w_step, w_expire, w_disarm;
  logic [15:0] w_cnt_cur, w_dec;
  logic [1:0]  w_low;
  logic [7:0]  w_vec, w_do;

  assign w_wr      = bus.cs & ~bus.rw;
  assign w_tick    = (r_pc == 16'd0);
  assign w_wr_ctrl = w_wr && (bus.AD == 4'h2);

  always_comb begin
    w_wr_cnt  = 4'b0000;
    w_wr_hold = 1'b0;
    for (int n = 0; n < 4; n++) begin
      if (w_wr && (n < NCH) && (bus.AD == 4'(8 + 2 * n))) w_wr_hold = 1'b1;
      if (w_wr && (n < NCH) && (bus.AD == 4'(9 + 2 * n))) w_wr_cnt[n] = 1'b1;
    end
  end

  // A bus write to CTRL or to this channel's counter pre-empts its sweep step entirely.
  assign w_en_cur   = r_ctrl[{1'b0, r_idx}];
  assign w_per_cur  = r_ctrl[{1'b1, r_idx}];
  assign w_cnt_cur  = r_cnt[r_idx];
  assign w_dec      = w_cnt_cur - 16'd1;
  assign w_step     = (r_state == SWEEP) && w_en_cur && (w_cnt_cur != 16'd0) &&
                      !w_wr_ctrl && !w_wr_cnt[r_idx];
  assign w_expire   = w_step && (w_dec == 16'd0);
  assign w_disarm   = w_expire && (!w_per_cur || (r_rld[r_idx] == 16'd0));
  assign w_pend_set = w_expire ? (4'b0001 << r_idx) : 4'b0000;
  assign w_pend_clr = (w_wr && (bus.AD == 4'h3)) ? bus.DI[3:0] : 4'b0000;

  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_tick_pend_nxt = r_tick_pend;
    w_ovr_set       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_tick || r_tick_pend) begin
          w_state_nxt     = SWEEP;
          w_idx_nxt       = 2'd0;
          w_tick_pend_nxt = w_tick & r_tick_pend;
        end
      end
      SWEEP: begin
        if (r_idx == LAST_IDX) w_state_nxt = IDLE;
        else                   w_idx_nxt   = r_idx + 2'd1;
        if (w_tick) begin
          if (r_tick_pend) w_ovr_set       = 1'b1;
          else             w_tick_pend_nxt = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_idx       <= 2'd0;
      r_tick_pend <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_tick_pend <= w_tick_pend_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= PRESC_RST;
      r_pc    <= PRESC_RST;
      r_ctrl  <= 8'h00;
      r_pend  <= 4'h0;
      r_mask  <= 4'h0;
      r_ovr   <= 1'b0;
      r_hold  <= 8'h00;
      r_intr  <= 1'b0;
      for (int n = 0; n < 4; n++) begin
        r_rld[n] <= 16'h0000;
        r_cnt[n] <= 16'h0000;
      end
    end else begin
      if (w_wr && (bus.AD == 4'h1)) r_pc <= {bus.DI, r_presc[7:0]};
      else if (w_tick)              r_pc <= r_presc;
      else                          r_pc <= r_pc - 16'd1;
      if (w_wr && (bus.AD == 4'h0)) r_presc[7:0]  <= bus.DI;
      if (w_wr && (bus.AD == 4'h1)) r_presc[15:8] <= bus.DI;
      if (w_wr && (bus.AD == 4'h4)) r_mask        <= bus.DI[3:0] & CH_MASK;
      if (w_wr_hold)                r_hold        <= bus.DI;

      if (w_wr_ctrl)     r_ctrl <= bus.DI & {CH_MASK, CH_MASK};
      else if (w_disarm) r_ctrl[{1'b0, r_idx}] <= 1'b0;

      r_pend <= (r_pend & ~w_pend_clr) | w_pend_set;

      if (w_ovr_set)                      r_ovr <= 1'b1;
      else if (w_wr && (bus.AD == 4'h6)) r_ovr <= 1'b0;

      for (int n = 0; n < 4; n++) begin
        if (w_wr_cnt[n]) begin
          r_rld[n] <= {bus.DI, r_hold};
          r_cnt[n] <= {bus.DI, r_hold};
        end else if (w_step && (r_idx == 2'(n))) begin
          if (w_expire) r_cnt[n] <= w_per_cur ? r_rld[n] : 16'h0000;
          else          r_cnt[n] <= w_dec;
        end
      end

      r_intr <= |(r_pend & r_mask);
    end
  end

  assign w_act = r_pend & r_mask;

  always_comb begin
    w_low = 2'd0;
    for (int n = 3; n >= 0; n--) begin
      if (w_act[n]) w_low = 2'(n);
    end
  end

  assign w_vec = {|w_act, 5'b00000, w_low};

  always_comb begin
    w_do = 8'h00;
    case (bus.AD)
      4'h0:    w_do = r_presc[7:0];
      4'h1:    w_do = r_presc[15:8];
      4'h2:    w_do = r_ctrl;
      4'h3:    w_do = {4'h0, r_pend};
      4'h4:    w_do = {4'h0, r_mask};
      4'h5:    w_do = w_vec;
      4'h6:    w_do = {7'b0000000, r_ovr};
      default: begin
        for (int n = 0; n < 4; n++) begin
          if (bus.AD[3] && (n < NCH) && (bus.AD[2:1] == 2'(n)))
            w_do = bus.AD[0] ? r_cnt[n][15:8] : r_cnt[n][7:0];
        end
      end
    endcase
  end

  assign bus.DO   = w_do;
  assign bus.intr = r_intr;
endmodule
